// File: rtl/noc_wb_ext_bridge_if.sv
// Bundle of the NoC request/response channels and the Wishbone lane
// handled by one noc_wb_ext_bridge instance.
//   master : bridge side (consumes requests, drives Wishbone, emits responses)
//   slave  : environment side (router ports plus the Wishbone slave)
interface noc_wb_ext_bridge_if;
  // NoC request channel (router -> bridge)
  logic [31:0] noc_in_flit;
  logic        noc_in_last;
  logic        noc_in_valid;
  logic        noc_in_ready;
  // NoC response channel (bridge -> router)
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready;
  // Wishbone master outputs
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        wb_cab_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  // Wishbone slave responses
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;

  modport master (
    input  noc_in_flit, noc_in_last, noc_in_valid,
    output noc_in_ready,
    output noc_out_flit, noc_out_last, noc_out_valid,
    input  noc_out_ready,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_cab_o, wb_cti_o, wb_bte_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );

  modport slave (
    output noc_in_flit, noc_in_last, noc_in_valid,
    input  noc_in_ready,
    input  noc_out_flit, noc_out_last, noc_out_valid,
    output noc_out_ready,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_cab_o, wb_cti_o, wb_bte_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );
endinterface

// File: rtl/noc_wb_ext_bridge.sv
// Purpose : terminates NoC request packets, runs one classic Wishbone master
//           cycle per packet on an external lane, and returns a response packet.
// Latency : Wishbone cyc/stb rise the cycle after the last request flit;
//           response header is valid the cycle after ack/err/rty-exhaust/timeout.
// Backpressure: one transaction in flight; noc_in_ready stays low from the
//           last request flit until the response packet has been accepted, and
//           the bridge stalls indefinitely while noc_out_ready is low.
// Ports   : clk, rst_n (async active-low), bus (noc_wb_ext_bridge_if.master).
module noc_wb_ext_bridge #(
  parameter int unsigned FLIT_WIDTH = 32,   // must be 32
  parameter logic [4:0]  TILE_ID    = 5'd0,
  parameter int unsigned TIMEOUT    = 255,  // 1..1023
  parameter int unsigned MAX_RETRY  = 3     // 0..7
) (
  input  logic                clk,
  input  logic                rst_n,
  noc_wb_ext_bridge_if.master bus
);

  localparam logic [9:0] TMO_MAX = 10'(TIMEOUT);
  localparam logic [2:0] RTY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_DATA, S_DRAIN, S_WB, S_RESP_HDR, S_RESP_DAT
  } state_t;

  state_t                state_q;
  logic [4:0]            src_q;
  logic                  we_q;
  logic                  err_q;
  logic [FLIT_WIDTH-1:0] adr_q;
  logic [FLIT_WIDTH-1:0] wdat_q;
  logic [FLIT_WIDTH-1:0] rdat_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic                  out_vld_q;
  logic                  out_last_q;
  logic                  in_rdy_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  wbwe_q;
  logic [3:0]            sel_q;
  logic [9:0]            tmo_q;
  logic [2:0]            retry_q;

  logic in_hs;
  logic out_hs;

  assign in_hs  = bus.noc_in_valid & in_rdy_q;
  assign out_hs = out_vld_q & bus.noc_out_ready;

  function automatic logic [31:0] rsp_hdr(input logic [4:0] src, input logic we,
                                          input logic err);
    return {src, TILE_ID, we, err, 20'h0_0000};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      src_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      out_flit_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      wbwe_q     <= 1'b0;
      sel_q      <= 4'h0;
      tmo_q      <= '0;
      retry_q    <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          // in_rdy_q is low only in the first cycle after reset release.
          in_rdy_q <= 1'b1;
          if (in_hs) begin
            src_q   <= bus.noc_in_flit[26:22];
            we_q    <= bus.noc_in_flit[21];
            retry_q <= '0;
            if (bus.noc_in_last) begin
              err_q      <= 1'b1;
              out_flit_q <= rsp_hdr(bus.noc_in_flit[26:22], bus.noc_in_flit[21], 1'b1);
              out_last_q <= 1'b1;
              out_vld_q  <= 1'b1;
              in_rdy_q   <= 1'b0;
              state_q    <= S_RESP_HDR;
            end else begin
              state_q <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (in_hs) begin
            adr_q <= bus.noc_in_flit;
            if (!we_q && bus.noc_in_last) begin
              cyc_q    <= 1'b1;
              stb_q    <= 1'b1;
              sel_q    <= 4'hF;
              wbwe_q   <= 1'b0;
              tmo_q    <= '0;
              in_rdy_q <= 1'b0;
              state_q  <= S_WB;
            end else if (we_q && !bus.noc_in_last) begin
              state_q <= S_DATA;
            end else if (!bus.noc_in_last) begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              err_q      <= 1'b1;
              out_flit_q <= rsp_hdr(src_q, we_q, 1'b1);
              out_last_q <= 1'b1;
              out_vld_q  <= 1'b1;
              in_rdy_q   <= 1'b0;
              state_q    <= S_RESP_HDR;
            end
          end
        end

        S_DATA: begin
          if (in_hs) begin
            wdat_q <= bus.noc_in_flit;
            if (bus.noc_in_last) begin
              cyc_q    <= 1'b1;
              stb_q    <= 1'b1;
              sel_q    <= 4'hF;
              wbwe_q   <= 1'b1;
              tmo_q    <= '0;
              in_rdy_q <= 1'b0;
              state_q  <= S_WB;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (in_hs && bus.noc_in_last) begin
            err_q      <= 1'b1;
            out_flit_q <= rsp_hdr(src_q, we_q, 1'b1);
            out_last_q <= 1'b1;
            out_vld_q  <= 1'b1;
            in_rdy_q   <= 1'b0;
            state_q    <= S_RESP_HDR;
          end
        end

        S_WB: begin
          if (!stb_q) begin
            // One-cycle idle gap after a retry has elapsed: re-issue.
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            sel_q  <= 4'hF;
            wbwe_q <= we_q;
            tmo_q  <= '0;
          end else if (bus.wb_ack_i) begin
            if (!we_q) rdat_q <= bus.wb_dat_i;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            sel_q      <= 4'h0;
            wbwe_q     <= 1'b0;
            err_q      <= 1'b0;
            out_flit_q <= rsp_hdr(src_q, we_q, 1'b0);
            out_last_q <= we_q;
            out_vld_q  <= 1'b1;
            state_q    <= S_RESP_HDR;
          end else if (bus.wb_err_i || (tmo_q == TMO_MAX) ||
                       (bus.wb_rty_i && (retry_q >= RTY_MAX))) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            sel_q      <= 4'h0;
            wbwe_q     <= 1'b0;
            err_q      <= 1'b1;
            out_flit_q <= rsp_hdr(src_q, we_q, 1'b1);
            out_last_q <= 1'b1;
            out_vld_q  <= 1'b1;
            state_q    <= S_RESP_HDR;
          end else if (bus.wb_rty_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            sel_q   <= 4'h0;
            wbwe_q  <= 1'b0;
            retry_q <= retry_q + 3'd1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 10'd1;
          end
        end

        S_RESP_HDR: begin
          if (out_hs) begin
            if (!we_q && !err_q) begin
              out_flit_q <= rdat_q;
              out_last_q <= 1'b1;
              state_q    <= S_RESP_DAT;
            end else begin
              out_vld_q  <= 1'b0;
              out_last_q <= 1'b0;
              in_rdy_q   <= 1'b1;
              state_q    <= S_HDR;
            end
          end
        end

        S_RESP_DAT: begin
          if (out_hs) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            in_rdy_q   <= 1'b1;
            state_q    <= S_HDR;
          end
        end

        default: begin
          state_q <= S_HDR;
        end
      endcase
    end
  end

  assign bus.noc_in_ready  = in_rdy_q;
  assign bus.noc_out_flit  = out_flit_q;
  assign bus.noc_out_last  = out_last_q;
  assign bus.noc_out_valid = out_vld_q;

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = wdat_q;
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = stb_q;
  assign bus.wb_we_o  = wbwe_q;
  // Classic single cycles only: no bursts.
  assign bus.wb_cab_o = 1'b0;
  assign bus.wb_cti_o = 3'b000;
  assign bus.wb_bte_o = 2'b00;

endmodule

// File: tb/tb_noc_wb_ext_bridge.sv
// Directed bench for noc_wb_ext_bridge (TILE_ID=9, TIMEOUT=8, MAX_RETRY=3).
// Response header = {SRC, TILE_ID, WE, ERR, 20'b0}; TILE_ID<<22 = 0x0240_0000.
module tb_noc_wb_ext_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_wb_ext_bridge_if bus();

  noc_wb_ext_bridge #(
    .FLIT_WIDTH(32),
    .TILE_ID   (5'd9),
    .TIMEOUT   (8),
    .MAX_RETRY (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req_hdr(input logic [4:0] dest, input logic [4:0] src,
                                          input logic we);
    return {dest, src, we, 21'h0};
  endfunction

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic send(input logic [31:0] f, input logic l);
    int n;
    n = 0;
    bus.noc_in_flit  = f;
    bus.noc_in_last  = l;
    bus.noc_in_valid = 1'b1;
    while (!bus.noc_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.noc_in_ready, 1);
    @(negedge clk);
    bus.noc_in_valid = 1'b0;
    bus.noc_in_last  = 1'b0;
  endtask

  // Expects noc_out_ready=1; returns at the negedge after the handshake.
  task automatic recv(input string tag, input logic [31:0] f, input logic l);
    int n;
    n = 0;
    while (!bus.noc_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"},  bus.noc_out_valid, 1);
    check({tag, "_flit"}, bus.noc_out_flit, f);
    check({tag, "_last"}, bus.noc_out_last, l);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    int extra;

    bus.noc_in_flit   = '0;
    bus.noc_in_last   = 1'b0;
    bus.noc_in_valid  = 1'b0;
    bus.noc_out_ready = 1'b1;
    bus.wb_ack_i      = 1'b0;
    bus.wb_err_i      = 1'b0;
    bus.wb_rty_i      = 1'b0;
    bus.wb_dat_i      = '0;
    rst_n             = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_in_rdy", bus.noc_in_ready, 0);
    check("rst_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
                       bus.noc_out_valid, bus.noc_out_last}, 0);
    check("rst_flit", bus.noc_out_flit, 0);
    check("rst_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", bus.noc_in_ready, 1);

    // ---- write, ack after 2 wait states ----
    send(req_hdr(5'd1, 5'd5, 1'b1), 1'b0);
    send(32'h0000_1000, 1'b0);
    send(32'hDEAD_BEEF, 1'b1);
    check("wr_cycle", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 7'b111_1111);
    check("wr_burst_ctl", {bus.wb_cab_o, bus.wb_cti_o, bus.wb_bte_o}, 0);
    check("wr_adr", bus.wb_adr_o, 32'h0000_1000);
    check("wr_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
    check("wr_in_rdy", bus.noc_in_ready, 0);
    repeat (2) @(negedge clk);
    check("wr_wait", {bus.wb_cyc_o, bus.wb_stb_o, bus.noc_out_valid}, 3'b110);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check("wr_cyc_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.noc_out_valid}, 3'b001);
    recv("wr_rsp", 32'h2A60_0000, 1'b1);

    // ---- read, zero-wait slave ----
    send(req_hdr(5'd2, 5'd3, 1'b0), 1'b0);
    send(32'h0000_0020, 1'b1);
    check("rd_cycle", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 7'b110_1111);
    check("rd_adr", bus.wb_adr_o, 32'h0000_0020);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'hFFFF_FFFF;
    check("rd_cyc_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.noc_out_valid}, 3'b001);
    recv("rd_hdr", 32'h1A40_0000, 1'b0);
    check("rd_dat_now", bus.noc_out_valid, 1);
    recv("rd_dat", 32'h1234_5678, 1'b1);
    check("rd_done", {bus.noc_out_valid, bus.noc_in_ready}, 2'b01);

    // ---- 3 retries then ack ----
    pulses = 0;
    send(req_hdr(5'd0, 5'd2, 1'b1), 1'b0);
    send(32'h0000_0300, 1'b0);
    send(32'h0000_55AA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (bus.wb_stb_o) pulses++;
      bus.wb_rty_i = 1'b1;
      @(negedge clk);
      bus.wb_rty_i = 1'b0;
      check("rty_gap", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
      @(negedge clk);
    end
    if (bus.wb_stb_o) pulses++;
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check("rty_pulses", pulses, 4);
    recv("rty_rsp", 32'h1260_0000, 1'b1);

    // ---- 4 retries: exhausted ----
    pulses = 0;
    send(req_hdr(5'd0, 5'd2, 1'b1), 1'b0);
    send(32'h0000_0304, 1'b0);
    send(32'h0000_66BB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_stb_o) pulses++;
      bus.wb_rty_i = 1'b1;
      @(negedge clk);
      bus.wb_rty_i = 1'b0;
      if (i < 3) begin
        check("rty4_gap", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
        @(negedge clk);
      end
    end
    check("rty4_cyc", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
    recv("rty4_rsp", 32'h1270_0000, 1'b1);
    extra = 0;
    repeat (3) begin
      if (bus.wb_stb_o) extra++;
      @(negedge clk);
    end
    check("rty4_pulses", pulses, 4);
    check("rty4_no_5th", extra, 0);

    // ---- timeout ----
    send(req_hdr(5'd3, 5'd7, 1'b0), 1'b0);
    send(32'h0000_0040, 1'b1);
    n = 0;
    while (bus.wb_stb_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", n, 9);
    check("tmo_cyc", bus.wb_cyc_o, 0);
    recv("tmo_rsp", 32'h3A50_0000, 1'b1);

    // ---- malformed: 4-flit write, then 1-flit packet ----
    send(req_hdr(5'd1, 5'd4, 1'b1), 1'b0);
    send(32'h0000_0500, 1'b0);
    send(32'h0000_1111, 1'b0);
    check("mal_no_wb_a", {bus.wb_cyc_o, bus.wb_stb_o, bus.noc_in_ready}, 3'b001);
    send(32'h0000_2222, 1'b1);
    check("mal_no_wb_b", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
    recv("mal_rsp", 32'h2270_0000, 1'b1);
    send(req_hdr(5'd2, 5'd1, 1'b0), 1'b1);
    check("one_no_wb", {bus.wb_cyc_o, bus.wb_stb_o, bus.noc_in_ready}, 0);
    recv("one_rsp", 32'h0A50_0000, 1'b1);

    // ---- response backpressure ----
    bus.noc_out_ready = 1'b0;
    send(req_hdr(5'd0, 5'd6, 1'b0), 1'b0);
    send(32'h0000_0044, 1'b1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {bus.noc_out_valid, bus.noc_in_ready, bus.noc_out_flit},
            {1'b1, 1'b0, 32'h3240_0000});
      @(negedge clk);
    end
    bus.noc_out_ready = 1'b1;
    recv("bp_hdr", 32'h3240_0000, 1'b0);
    recv("bp_dat", 32'hA5A5_0F0F, 1'b1);

    // ---- reset during WB ----
    send(req_hdr(5'd0, 5'd2, 1'b1), 1'b0);
    send(32'h0000_0600, 1'b0);
    send(32'h0000_0077, 1'b1);
    check("rst_pre", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
    check("rst_mid_ctrl", {bus.noc_in_ready, bus.noc_out_valid, bus.noc_out_last,
                           bus.wb_we_o, bus.wb_sel_o}, 0);
    check("rst_mid_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 0);
    check("rst_mid_flit", bus.noc_out_flit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.noc_out_valid || bus.wb_cyc_o) extra++;
    end
    check("rst_no_rsp", extra, 0);
    check("rst_rdy_back", bus.noc_in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
